// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix operand loader and its packing register.
//   - load_state_e : loader FSM encoding, kept in the 3-bit state width the
//                    multiplier uses so both can be probed with the same decode.
//   - DEF_*        : default matrix dimensions and element width.
//   - matrix_weight / count_width : element-count and counter-width helpers.
package matrix_pkg;

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3
  } load_state_e;

  localparam int DEF_FIRST_MATRIX_HEIGHT = 5;
  localparam int DEF_BOTH_MATRIX_W_H     = 5;
  localparam int DEF_SECOND_MATRIX_WIDTH = 5;
  localparam int DEF_DATA_WIDTH          = 8;

  // Number of elements in a rows x cols matrix.
  function automatic int matrix_weight(input int rows, input int cols);
    return rows * cols;
  endfunction

  // Counter width able to hold the larger of the two element counts.
  function automatic int count_width(input int w1, input int w2);
    int m;
    m = (w1 > w2) ? w1 : w2;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/matrix_pack_reg.sv
// Element-indexed packing register. Each write stores one DATA_WIDTH element
// at o_bus[i_idx*DATA_WIDTH +: DATA_WIDTH]; untouched elements keep their value.
// Ports:
//   clk, i_rst  : clock, synchronous active-high reset (clears the whole bus)
//   i_we        : write enable for this cycle
//   i_idx       : element index, 0 .. N_ELEMS-1
//   i_data      : element value
//   o_bus       : flat packed bus, element 0 in the least-significant slot
module matrix_pack_reg #(
  parameter int N_ELEMS    = 25,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = 5
) (
  input  logic                          clk,
  input  logic                          i_rst,
  input  logic                          i_we,
  input  logic [IDX_W-1:0]              i_idx,
  input  logic [DATA_WIDTH-1:0]         i_data,
  output logic [N_ELEMS*DATA_WIDTH-1:0] o_bus
);

  logic [N_ELEMS*DATA_WIDTH-1:0] bus_q, bus_d;

  always_comb begin
    bus_d = bus_q;
    // Out-of-range indices are dropped rather than wrapping into another slot.
    if (i_we && (int'(i_idx) < N_ELEMS)) begin
      bus_d[int'(i_idx)*DATA_WIDTH +: DATA_WIDTH] = i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      bus_q <= '0;
    end else begin
      bus_q <= bus_d;
    end
  end

  assign o_bus = bus_q;

endmodule

// File: rtl/matrix_operand_loader.sv
// Upstream feeder for the matrix-by-matrix multiplier.
// Collects a serial element stream, packs matrix 1 then matrix 2 row-major,
// pulses o_calc, then waits for a rising edge of the multiplier's ready
// before pulsing o_done and accepting the next operand pair.
// Ports:
//   clk, i_rst     : clock, synchronous active-high reset
//   i_data/i_valid : element stream in; o_in_ready is the loader's ready
//   i_flush        : restart the load sequence at element 0 of matrix 1
//   i_mult_ready   : multiplier ready (completion = its rising edge)
//   o_calc         : one-cycle start pulse to the multiplier
//   o_matrix_1/2   : packed operands, held from last write until next load
//   o_done         : one-cycle completion pulse
//   o_busy         : high while the multiplier owns the operands
// Handshake: an element is consumed on a rising clk edge where
// i_valid && o_in_ready; o_in_ready is registered and depends only on the
// loader state, never on i_valid, and i_data is ignored when not consumed.
module matrix_operand_loader
  import matrix_pkg::*;
#(
  parameter int FIRST_MATRIX_HEIGHT = DEF_FIRST_MATRIX_HEIGHT,
  parameter int BOTH_MATRIX_W_H     = DEF_BOTH_MATRIX_W_H,
  parameter int SECOND_MATRIX_WIDTH = DEF_SECOND_MATRIX_WIDTH,
  parameter int DATA_WIDTH          = DEF_DATA_WIDTH
) (
  input  logic                                                    clk,
  input  logic                                                    i_rst,
  input  logic [DATA_WIDTH-1:0]                                   i_data,
  input  logic                                                    i_valid,
  output logic                                                    o_in_ready,
  input  logic                                                    i_flush,
  input  logic                                                    i_mult_ready,
  output logic                                                    o_calc,
  output logic [FIRST_MATRIX_HEIGHT*BOTH_MATRIX_W_H*DATA_WIDTH-1:0] o_matrix_1,
  output logic [BOTH_MATRIX_W_H*SECOND_MATRIX_WIDTH*DATA_WIDTH-1:0] o_matrix_2,
  output logic                                                    o_done,
  output logic                                                    o_busy
);

  localparam int FIRST_MATRIX_WEIGHT  = matrix_weight(FIRST_MATRIX_HEIGHT, BOTH_MATRIX_W_H);
  localparam int SECOND_MATRIX_WEIGHT = matrix_weight(BOTH_MATRIX_W_H, SECOND_MATRIX_WIDTH);
  localparam int CNT_W = count_width(FIRST_MATRIX_WEIGHT, SECOND_MATRIX_WEIGHT);

  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(FIRST_MATRIX_WEIGHT - 1);
  localparam logic [CNT_W-1:0] B_LAST = CNT_W'(SECOND_MATRIX_WEIGHT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  load_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mult_ready_q;
  logic             in_ready_q, in_ready_d;
  logic             calc_q, calc_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             xfer;
  logic             we_a, we_b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    we_a    = 1'b0;
    we_b    = 1'b0;
    xfer    = i_valid && in_ready_q;

    case (state_q)
      LOAD_A: begin
        // Flush beats a simultaneous transfer: that element is dropped.
        if (i_flush) begin
          cnt_d = '0;
        end else if (xfer) begin
          we_a = 1'b1;
          if (cnt_q == A_LAST) begin
            state_d = LOAD_B;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      LOAD_B: begin
        if (i_flush) begin
          state_d = LOAD_A;
          cnt_d   = '0;
        end else if (xfer) begin
          we_b = 1'b1;
          if (cnt_q == B_LAST) begin
            state_d = START;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Only a fresh rising edge completes; a level left high from the
        // previous result is already reflected in mult_ready_q.
        if (i_mult_ready && !mult_ready_q) begin
          state_d = LOAD_A;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = LOAD_A;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered versions of what the next state implies.
    in_ready_d = (state_d == LOAD_A) || (state_d == LOAD_B);
    busy_d     = (state_d == START) || (state_d == WAIT);
    calc_d     = (state_d == START);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q      <= LOAD_A;
      cnt_q        <= '0;
      mult_ready_q <= 1'b0;
      in_ready_q   <= 1'b1;
      calc_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mult_ready_q <= i_mult_ready;
      in_ready_q   <= in_ready_d;
      calc_q       <= calc_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  matrix_pack_reg #(
    .N_ELEMS   (FIRST_MATRIX_WEIGHT),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (CNT_W)
  ) u_pack_a (
    .clk   (clk),
    .i_rst (i_rst),
    .i_we  (we_a),
    .i_idx (cnt_q),
    .i_data(i_data),
    .o_bus (o_matrix_1)
  );

  matrix_pack_reg #(
    .N_ELEMS   (SECOND_MATRIX_WEIGHT),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (CNT_W)
  ) u_pack_b (
    .clk   (clk),
    .i_rst (i_rst),
    .i_we  (we_b),
    .i_idx (cnt_q),
    .i_data(i_data),
    .o_bus (o_matrix_2)
  );

  assign o_in_ready = in_ready_q;
  assign o_calc     = calc_q;
  assign o_done     = done_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Self-checking bench for matrix_operand_loader at default 5x5x5, 8-bit.
// A behavioural model tracks accepted elements per operand pair and the
// expected handshake outputs; a negedge process compares every cycle.
module tb_matrix_operand_loader;

  localparam int DW = 8;
  localparam int NA = 25;
  localparam int NB = 25;

  logic            clk;
  logic            i_rst;
  logic [DW-1:0]   i_data;
  logic            i_valid;
  logic            o_in_ready;
  logic            i_flush;
  logic            i_mult_ready;
  logic            o_calc;
  logic [NA*DW-1:0] o_matrix_1;
  logic [NB*DW-1:0] o_matrix_2;
  logic            o_done;
  logic            o_busy;

  matrix_operand_loader dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_in_ready  (o_in_ready),
    .i_flush     (i_flush),
    .i_mult_ready(i_mult_ready),
    .o_calc      (o_calc),
    .o_matrix_1  (o_matrix_1),
    .o_matrix_2  (o_matrix_2),
    .o_done      (o_done),
    .o_busy      (o_busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;
  int calc_seen = 0;
  int done_seen = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_a[NA];
  logic [DW-1:0] m_b[NB];
  int   m_cnt = 0;      // elements accepted in the current operand pair
  bit   m_ready = 1, m_busy = 0, m_calc = 0, m_done = 0, m_mr_prev = 0;

  initial begin
    bit was_calc;
    forever begin
      @(posedge clk);
      if (i_rst) begin
        for (int k = 0; k < NA; k++) m_a[k] = '0;
        for (int k = 0; k < NB; k++) m_b[k] = '0;
        m_cnt = 0; m_ready = 1; m_busy = 0; m_calc = 0; m_done = 0; m_mr_prev = 0;
      end else begin
        was_calc = m_calc;
        m_calc = 0;
        m_done = 0;
        if (m_ready) begin
          if (i_flush) m_cnt = 0;
          else if (i_valid) begin
            if (m_cnt < NA) m_a[m_cnt] = i_data;
            else m_b[m_cnt - NA] = i_data;
            m_cnt++;
            if (m_cnt == NA + NB) begin
              m_cnt = 0; m_ready = 0; m_busy = 1; m_calc = 1;
            end
          end
        end else if (!was_calc && i_mult_ready && !m_mr_prev) begin
          m_done = 1; m_busy = 0; m_ready = 1;
        end
        m_mr_prev = i_mult_ready;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [NA*DW-1:0] e1;
    logic [NB*DW-1:0] e2;
    if (chk_en) begin
      for (int k = 0; k < NA; k++) e1[k*DW +: DW] = m_a[k];
      for (int k = 0; k < NB; k++) e2[k*DW +: DW] = m_b[k];
      check("in_ready", 256'(o_in_ready), 256'(m_ready));
      check("busy",     256'(o_busy),     256'(m_busy));
      check("calc",     256'(o_calc),     256'(m_calc));
      check("done",     256'(o_done),     256'(m_done));
      check("matrix_1", 256'(o_matrix_1), 256'(e1));
      check("matrix_2", 256'(o_matrix_2), 256'(e2));
      if (o_calc === 1'b1) calc_seen++;
      if (o_done === 1'b1) done_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [DW-1:0] v, input int max_gap);
    bit ok;
    int g;
    g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    repeat (g) begin
      i_data = DW'($urandom_range(0, 255));
      cycles(1);
    end
    i_valid = 1'b1;
    i_data  = v;
    ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (o_in_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    if (!ok) check("send_timeout", 256'(0), 256'(1));
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (o_in_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    if (!ok) check("idle_timeout", 256'(0), 256'(1));
  endtask

  // Produce a 0 -> 1 edge on the multiplier ready and wait for the loader.
  task automatic mult_finish();
    i_mult_ready = 1'b0;
    cycles(2);
    i_mult_ready = 1'b1;
    wait_idle();
  endtask

  task automatic send_random(input int n, input int max_gap);
    for (int k = 0; k < n; k++) send(DW'($urandom_range(0, 255)), max_gap);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0, d0;
    i_rst = 1'b1; i_data = '0; i_valid = 1'b0; i_flush = 1'b0; i_mult_ready = 1'b0;
    @(posedge clk); #1;
    chk_en = 1;
    cycles(1);
    i_rst = 1'b0;
    check("rst_in_ready", 256'(o_in_ready), 256'(1));
    check("rst_matrix_1", 256'(o_matrix_1), 256'(0));
    check("rst_busy",     256'({o_calc, o_done, o_busy}), 256'(0));

    // Pair 1: A = 1..25, B = identity; ready high before calc, then 1->0->1.
    i_mult_ready = 1'b1;
    for (int k = 0; k < NA; k++) send(DW'(k + 1), 0);
    for (int k = 0; k < NB; k++) send(DW'((k / 5 == k % 5) ? 1 : 0), 0);
    i_valid = 1'b1; i_data = 8'hAA;   // held high while busy: must be ignored
    cycles(6);
    i_valid = 1'b0;
    check("t1_m1_first", 256'(o_matrix_1[7:0]),     256'(8'd1));
    check("t1_m1_last",  256'(o_matrix_1[199:192]), 256'(8'd25));
    check("t1_m2_diag",  256'(o_matrix_2[55:48]),   256'(8'd1));
    check("t1_m2_off",   256'(o_matrix_2[15:8]),    256'(8'd0));
    check("t1_calc_cnt", 256'(calc_seen), 256'(1));
    check("t1_no_done",  256'(done_seen), 256'(0));
    mult_finish();
    check("t1_done_cnt", 256'(done_seen), 256'(1));

    // Pair 2: value = index with random gaps; ready left high from pair 1.
    for (int k = 0; k < NA; k++) send(DW'(k), 3);
    for (int k = 0; k < NB; k++) send(DW'(k), 3);
    d0 = done_seen;
    cycles(10);
    check("t2_still_busy", 256'(o_busy), 256'(1));
    check("t2_no_early",   256'(done_seen), 256'(d0));
    check("t2_m1_idx24",   256'(o_matrix_1[199:192]), 256'(8'd24));
    mult_finish();

    // Flush after 10 A elements (with a colliding valid), then 100..124.
    send_random(10, 1);
    i_flush = 1'b1; i_valid = 1'b1; i_data = 8'hEE;
    cycles(1);
    i_flush = 1'b0; i_valid = 1'b0;
    for (int k = 0; k < NA; k++) send(DW'(100 + k), 1);
    send_random(NB, 1);
    mult_finish();
    check("fl_m1_first", 256'(o_matrix_1[7:0]),     256'(8'd100));
    check("fl_m1_last",  256'(o_matrix_1[199:192]), 256'(8'd124));

    // Reset after 30 transfers, then a fresh full sequence.
    send_random(30, 1);
    i_rst = 1'b1;
    cycles(1);
    i_rst = 1'b0;
    check("rs_m1",       256'(o_matrix_1), 256'(0));
    check("rs_m2",       256'(o_matrix_2), 256'(0));
    check("rs_outs",     256'({o_calc, o_done, o_busy}), 256'(0));
    check("rs_in_ready", 256'(o_in_ready), 256'(1));
    c0 = calc_seen;
    send_random(NA + NB, 2);
    cycles(2);
    check("rs_calc", 256'(calc_seen), 256'(c0 + 1));
    mult_finish();

    // Reset and flush together during LOAD_B.
    send_random(NA + 5, 1);
    i_rst = 1'b1; i_flush = 1'b1;
    cycles(1);
    i_rst = 1'b0; i_flush = 1'b0;
    check("rf_m1", 256'(o_matrix_1), 256'(0));
    check("rf_m2", 256'(o_matrix_2), 256'(0));

    // Random pairs with random completion timing.
    for (int p = 0; p < 3; p++) begin
      send_random(NA + NB, 2);
      cycles(int'($urandom_range(1, 6)));
      mult_finish();
    end

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/matrix_operand_loader.md
Name: matrix_operand_loader

Overview:
- Upstream feeder for the matrix-by-matrix multiplier.
- Accepts a serial stream of DATA_WIDTH elements over a valid/ready handshake, packs them row-major into the two flat operand buses, then pulses the multiplier's calc input.
- Waits for the multiplier's ready to rise, signals completion, then accepts the next operand pair.

Parameters:
- FIRST_MATRIX_HEIGHT, 5, rows of matrix 1
- BOTH_MATRIX_W_H, 5, columns of matrix 1 = rows of matrix 2
- SECOND_MATRIX_WIDTH, 5, columns of matrix 2
- DATA_WIDTH, 8, element width in bits
- Derived: FIRST_MATRIX_WEIGHT = FIRST_MATRIX_HEIGHT*BOTH_MATRIX_W_H
- Derived: SECOND_MATRIX_WEIGHT = BOTH_MATRIX_W_H*SECOND_MATRIX_WIDTH
- Derived: CNT_W = $clog2(max(weights)+1)

Ports:
- clk  input  1  clock; single clock domain
- i_rst  input  1  reset, synchronous, active-high
- i_data  input  DATA_WIDTH  stream element
- i_valid  input  1  i_data valid
- o_in_ready  output  1  loader accepts an element this cycle
- i_flush  input  1  soft restart of the load sequence
- i_mult_ready  input  1  multiplier's ready output
- o_calc  output  1  one-cycle start pulse to the multiplier
- o_matrix_1  output  FIRST_MATRIX_WEIGHT*DATA_WIDTH  packed matrix 1
- o_matrix_2  output  SECOND_MATRIX_WEIGHT*DATA_WIDTH  packed matrix 2
- o_done  output  1  one-cycle pulse when the multiplier result is ready
- o_busy  output  1  high in START or WAIT

Behaviour:
- Reset: all outputs are driven from registers and reset together on a rising clk edge with i_rst=1.
  - State LOAD_A, counter 0, mult_ready_q 0.
  - o_matrix_1 = o_matrix_2 = 0.
  - o_calc = o_done = o_busy = 0; o_in_ready = 1 on the first cycle after reset.
- Reset mid-operation: abandons any load or wait and clears both matrices.
- Transfer occurs when i_valid && o_in_ready. o_in_ready = 1 only in LOAD_A and LOAD_B.
- LOAD_A:
  - Element k is written to o_matrix_1[k*DATA_WIDTH +: DATA_WIDTH]; k = row*BOTH_MATRIX_W_H + col, streamed row-major.
  - Counter increments per transfer.
  - Transfer at k = FIRST_MATRIX_WEIGHT-1 goes to LOAD_B with counter 0.
- LOAD_B:
  - Same packing into o_matrix_2; k = row*SECOND_MATRIX_WIDTH + col.
  - Last transfer goes to START.
- START: o_calc = 1 for exactly one cycle, then WAIT.
- WAIT:
  - Completion is detected on a rising edge of i_mult_ready, using mult_ready_q registered every cycle.
  - A level-high i_mult_ready left over from the previous result never completes early.
  - On the edge: o_done = 1 for one cycle, state returns to LOAD_A, counter 0.
- Operand buses hold their values from the last write through START and WAIT. They are overwritten element by element only during the next load.
- i_valid outside LOAD_A/LOAD_B is ignored; no data is consumed.
- i_flush:
  - In LOAD_A/LOAD_B: goes to LOAD_A with counter 0 next cycle; matrix contents are kept; any simultaneous transfer is dropped.
  - Ignored in START/WAIT.
- i_rst has priority over i_flush; i_flush has priority over a transfer.
- Minimum latency, last B element accepted to o_calc: 1 cycle (START is entered on the next edge).
- No arithmetic on data; elements are copied bit-exact.

Decomposition:
- Shared package matrix_pkg:
  - state encoding LOAD_A=0, LOAD_B=1, START=2, WAIT=3, in the 3-bit state width the multiplier uses;
  - default dimension/DATA_WIDTH constants;
  - weight/size helper functions.
- One natural sub-module, matrix_pack_reg: a parameterised element-indexed packing register (write-enable, index, data in; flat bus out). Instantiated once for each operand.

Test Plan:
- Default 5x5x5 params. Stream 25 A elements = 1..25, then 25 B elements as identity.
  - o_matrix_1[7:0]=1, o_matrix_1[199:192]=25.
  - o_calc pulses exactly once, 1 cycle after the 50th transfer.
  - Drive i_mult_ready 1→0→1 → o_done pulses once; state returns to LOAD_A.
- Backpressure/gaps: i_valid toggled randomly with value = index.
  - Every element lands at offset index*8; no duplicates or drops.
  - o_in_ready = 0 throughout START/WAIT even with i_valid held high.
- i_mult_ready held at 1 from the previous run when o_calc fires.
  - No o_done until it drops and rises again.
- Assert i_flush after 10 A elements, then stream 25 fresh values 100..124.
  - o_matrix_1 = 100..124; A and B count restarts.
- Assert i_rst after 30 transfers.
  - Next cycle: both matrices 0, o_calc/o_done/o_busy 0, o_in_ready 1, a fresh sequence loads correctly.
- i_rst and i_flush together during LOAD_B.
  - Reset behaviour wins; matrices are cleared.
